// File: rtl/rooth_clint_pkg.sv
// Shared types and constants for the rooth core-local interrupt/trap sequencer.
package rooth_clint_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MSTATUS = 3'd1,
    S_MEPC    = 3'd2,
    S_MCAUSE  = 3'd3,
    S_ASSERT  = 3'd4,
    S_MRET    = 3'd5
  } clint_state_e;

  localparam int unsigned CSR_ADDR_W = 12;

  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;

endpackage

// File: rtl/rooth_clint_int_sync.sv
// Parameterised 2-flop synchronizer for the external interrupt lines (used under CLINT_INT_SYNC_EN).
module clint_int_sync #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rooth_clint.sv
// Core-local interrupt/trap sequencer: freezes the pipeline, writes mstatus/mepc/mcause, then redirects fetch.
// Define CLINT_INT_SYNC_EN to pass int_flag_i through a 2-flop synchronizer before use.
module rooth_clint
  import rooth_clint_pkg::*;
#(
  parameter int unsigned CPU_WIDTH = 32,
  parameter int unsigned INT_NUM   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INT_NUM-1:0]    int_flag_i,
  input  logic                  ex_valid_i,
  input  logic [CPU_WIDTH-1:0]  ex_pc_i,
  input  logic                  inst_ecall_i,
  input  logic                  inst_ebreak_i,
  input  logic                  inst_mret_i,
  input  logic                  redirect_i,
  input  logic                  jtag_halt_flag_i,
  input  logic [CPU_WIDTH-1:0]  csr_mtvec_i,
  input  logic [CPU_WIDTH-1:0]  csr_mepc_i,
  input  logic [CPU_WIDTH-1:0]  csr_mstatus_i,
  output logic                  csr_we_o,
  output logic [CSR_ADDR_W-1:0] csr_waddr_o,
  output logic [CPU_WIDTH-1:0]  csr_wdata_o,
  output logic                  hold_flag_o,
  output logic [CPU_WIDTH-1:0]  int_addr_o,
  output logic                  int_assert_o
);

  clint_state_e          r_state, w_state_nxt;
  logic [CPU_WIDTH-1:0]  r_pc, w_pc_nxt;
  logic [CPU_WIDTH-1:0]  r_cause, w_cause_nxt;
  logic                  r_csr_we, w_csr_we_nxt;
  logic [CSR_ADDR_W-1:0] r_csr_waddr, w_csr_waddr_nxt;
  logic [CPU_WIDTH-1:0]  r_csr_wdata, w_csr_wdata_nxt;
  logic [CPU_WIDTH-1:0]  r_int_addr, w_int_addr_nxt;
  logic                  r_int_assert, w_int_assert_nxt;

  logic [INT_NUM-1:0]    w_int_flag;
  logic [CPU_WIDTH-1:0]  w_mst_trap;
  logic [CPU_WIDTH-1:0]  w_mst_mret;
  logic                  w_idle, w_sync_trap, w_mret, w_ext_int, w_trigger;

`ifdef CLINT_INT_SYNC_EN
  clint_int_sync #(.WIDTH(INT_NUM)) u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (int_flag_i),
    .o_q   (w_int_flag)
  );
`else
  assign w_int_flag = int_flag_i;
`endif

  // Event detection; external interrupts are deferred (not dropped) across redirects and debug halt.
  assign w_idle      = (r_state == S_IDLE);
  assign w_sync_trap = ex_valid_i && (inst_ecall_i || inst_ebreak_i);
  assign w_mret      = ex_valid_i && inst_mret_i;
  assign w_ext_int   = ex_valid_i && (|w_int_flag) && csr_mstatus_i[MSTATUS_MIE_BIT]
                       && !redirect_i && !jtag_halt_flag_i;
  assign w_trigger   = w_idle && (w_sync_trap || w_mret || w_ext_int);
  assign hold_flag_o = (!w_idle && (r_state != S_ASSERT)) || w_trigger;

  always_comb begin
    w_mst_trap                   = csr_mstatus_i;
    w_mst_trap[MSTATUS_MPIE_BIT] = csr_mstatus_i[MSTATUS_MIE_BIT];
    w_mst_trap[MSTATUS_MIE_BIT]  = 1'b0;
    w_mst_mret                   = csr_mstatus_i;
    w_mst_mret[MSTATUS_MIE_BIT]  = csr_mstatus_i[MSTATUS_MPIE_BIT];
    w_mst_mret[MSTATUS_MPIE_BIT] = 1'b1;
  end

  // Next state plus the values the output registers take in that next state.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_cause_nxt      = r_cause;
    w_csr_we_nxt     = 1'b0;
    w_csr_waddr_nxt  = '0;
    w_csr_wdata_nxt  = '0;
    w_int_addr_nxt   = '0;
    w_int_assert_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sync_trap || (!w_mret && w_ext_int)) begin
          w_state_nxt     = S_MSTATUS;
          w_pc_nxt        = ex_pc_i;
          w_cause_nxt     = w_sync_trap ? (inst_ecall_i ? CPU_WIDTH'(CAUSE_ECALL)
                                                        : CPU_WIDTH'(CAUSE_EBREAK))
                                        : CPU_WIDTH'(CAUSE_EXT_INT);
          w_csr_we_nxt    = 1'b1;
          w_csr_waddr_nxt = CSR_MSTATUS;
          w_csr_wdata_nxt = w_mst_trap;
        end else if (w_mret) begin
          w_state_nxt     = S_MRET;
          w_csr_we_nxt    = 1'b1;
          w_csr_waddr_nxt = CSR_MSTATUS;
          w_csr_wdata_nxt = w_mst_mret;
        end
      end
      S_MSTATUS: begin
        w_state_nxt     = S_MEPC;
        w_csr_we_nxt    = 1'b1;
        w_csr_waddr_nxt = CSR_MEPC;
        w_csr_wdata_nxt = r_pc;
      end
      S_MEPC: begin
        w_state_nxt     = S_MCAUSE;
        w_csr_we_nxt    = 1'b1;
        w_csr_waddr_nxt = CSR_MCAUSE;
        w_csr_wdata_nxt = r_cause;
      end
      S_MCAUSE: begin
        w_state_nxt      = S_ASSERT;
        w_int_assert_nxt = 1'b1;
        w_int_addr_nxt   = csr_mtvec_i;
      end
      S_MRET: begin
        w_state_nxt      = S_ASSERT;
        w_int_assert_nxt = 1'b1;
        w_int_addr_nxt   = csr_mepc_i;
      end
      S_ASSERT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_cause      <= '0;
      r_csr_we     <= 1'b0;
      r_csr_waddr  <= '0;
      r_csr_wdata  <= '0;
      r_int_addr   <= '0;
      r_int_assert <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_cause      <= w_cause_nxt;
      r_csr_we     <= w_csr_we_nxt;
      r_csr_waddr  <= w_csr_waddr_nxt;
      r_csr_wdata  <= w_csr_wdata_nxt;
      r_int_addr   <= w_int_addr_nxt;
      r_int_assert <= w_int_assert_nxt;
    end
  end

  assign csr_we_o     = r_csr_we;
  assign csr_waddr_o  = r_csr_waddr;
  assign csr_wdata_o  = r_csr_wdata;
  assign int_addr_o   = r_int_addr;
  assign int_assert_o = r_int_assert;

endmodule

// File: tb/tb_rooth_clint.sv
// Self-checking bench for rooth_clint with a CSR-file model and a cycle-level expectation model.
module tb_rooth_clint;

  localparam int unsigned CPU_WIDTH = 32;
  localparam int unsigned INT_NUM   = 8;
`ifdef CLINT_INT_SYNC_EN
  localparam int unsigned SYNC_D = 2;
`else
  localparam int unsigned SYNC_D = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [INT_NUM-1:0]   int_flag_i;
  logic                 ex_valid_i, inst_ecall_i, inst_ebreak_i, inst_mret_i;
  logic                 redirect_i, jtag_halt_flag_i;
  logic [CPU_WIDTH-1:0] ex_pc_i;
  logic [31:0]          mtvec, mepc, mstatus, mcause;
  logic                 csr_we_o, hold_flag_o, int_assert_o;
  logic [11:0]          csr_waddr_o;
  logic [CPU_WIDTH-1:0] csr_wdata_o, int_addr_o;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        hold;
    logic        asrt;
    logic [31:0] iaddr;
  } obs_t;

  obs_t exp_q[$];
  obs_t act;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rooth_clint #(.CPU_WIDTH(CPU_WIDTH), .INT_NUM(INT_NUM)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .int_flag_i       (int_flag_i),
    .ex_valid_i       (ex_valid_i),
    .ex_pc_i          (ex_pc_i),
    .inst_ecall_i     (inst_ecall_i),
    .inst_ebreak_i    (inst_ebreak_i),
    .inst_mret_i      (inst_mret_i),
    .redirect_i       (redirect_i),
    .jtag_halt_flag_i (jtag_halt_flag_i),
    .csr_mtvec_i      (mtvec),
    .csr_mepc_i       (mepc),
    .csr_mstatus_i    (mstatus),
    .csr_we_o         (csr_we_o),
    .csr_waddr_o      (csr_waddr_o),
    .csr_wdata_o      (csr_wdata_o),
    .hold_flag_o      (hold_flag_o),
    .int_addr_o       (int_addr_o),
    .int_assert_o     (int_assert_o)
  );

  function automatic obs_t cur();
    return {csr_we_o, csr_waddr_o, csr_wdata_o, hold_flag_o, int_assert_o, int_addr_o};
  endfunction

  // Expected trace from the detect cycle: entry writes 1..3 cycles later, redirect at +4, then idle.
  function automatic void build_trap(input logic [31:0] cause, input logic [31:0] pc,
                                     input logic [31:0] ms, input logic [31:0] tv);
    logic [31:0] nms;
    nms = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0);
    exp_q.delete();
    exp_q.push_back({1'b0, 12'h000, 32'h0,  1'b1, 1'b0, 32'h0});
    exp_q.push_back({1'b1, 12'h300, nms,    1'b1, 1'b0, 32'h0});
    exp_q.push_back({1'b1, 12'h341, pc,     1'b1, 1'b0, 32'h0});
    exp_q.push_back({1'b1, 12'h342, cause,  1'b1, 1'b0, 32'h0});
    exp_q.push_back({1'b0, 12'h000, 32'h0,  1'b0, 1'b1, tv});
    exp_q.push_back({1'b0, 12'h000, 32'h0,  1'b0, 1'b0, 32'h0});
  endfunction

  function automatic void build_mret(input logic [31:0] ms, input logic [31:0] epc);
    logic [31:0] nms;
    nms = (ms & ~32'h88) | (ms[7] ? 32'h8 : 32'h0) | 32'h80;
    exp_q.delete();
    exp_q.push_back({1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0});
    exp_q.push_back({1'b1, 12'h300, nms,   1'b1, 1'b0, 32'h0});
    exp_q.push_back({1'b0, 12'h000, 32'h0, 1'b0, 1'b1, epc});
    exp_q.push_back({1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0});
  endfunction

  // Advance one cycle; the CSR-file model commits whatever write was presented during it.
  task automatic step();
    logic        we;
    logic [11:0] a;
    logic [31:0] d;
    we = csr_we_o; a = csr_waddr_o; d = csr_wdata_o;
    @(posedge clk); #1;
    if (we && rst_n) begin
      case (a)
        12'h300: mstatus = d;
        12'h341: mepc    = d;
        12'h342: mcause  = d;
        default: ;
      endcase
    end
  endtask

  task automatic clear_ev();
    ex_valid_i = 0; inst_ecall_i = 0; inst_ebreak_i = 0; inst_mret_i = 0;
    redirect_i = 0; jtag_halt_flag_i = 0;
  endtask

  task automatic test_reset();
    clear_ev(); int_flag_i = '0; ex_pc_i = '0;
    mtvec = 32'h80; mepc = 0; mstatus = 0; mcause = 0;
    rst_n = 0;
    #1;
    n_tests++;
    if (cur() !== obs_t'(0)) begin
      n_fail++; $display("FAIL reset_outputs got %h exp 0", cur());
    end
    @(posedge clk); #1; rst_n = 1;
    step();
  endtask

  task automatic test_ecall();
    int kind;
    for (int it = 0; it < 17; it++) begin
      if (it == 0) begin
        kind = 0; ex_pc_i = 32'h100; mtvec = 32'h80; mstatus = 32'h8; redirect_i = 0;
      end else begin
        kind = int'($urandom_range(0, 1));
        ex_pc_i = $urandom & 32'hFFFF_FFFC; mtvec = $urandom & 32'hFFFF_FFFC;
        mstatus = $urandom; redirect_i = 1'($urandom_range(0, 1));
      end
      ex_valid_i = 1; inst_ecall_i = (kind == 0); inst_ebreak_i = (kind == 1);
      build_trap(kind == 0 ? 32'd11 : 32'd3, ex_pc_i, mstatus, mtvec);
      foreach (exp_q[c]) begin
        #1; act = cur(); n_tests++;
        if (act !== exp_q[c]) begin
          n_fail++; $display("FAIL sync_trap it%0d cyc%0d got %h exp %h", it, c, act, exp_q[c]);
        end
        step(); if (c == 0) clear_ev();
      end
    end
  endtask

  task automatic test_mret();
    for (int it = 0; it < 12; it++) begin
      if (it == 0) begin
        mepc = 32'h104; mstatus = 32'h80;
      end else begin
        mepc = $urandom & 32'hFFFF_FFFC; mstatus = $urandom;
      end
      ex_pc_i = $urandom; ex_valid_i = 1; inst_mret_i = 1;
      redirect_i = 1'($urandom_range(0, 1));
      build_mret(mstatus, mepc);
      foreach (exp_q[c]) begin
        #1; act = cur(); n_tests++;
        if (act !== exp_q[c]) begin
          n_fail++; $display("FAIL mret it%0d cyc%0d got %h exp %h", it, c, act, exp_q[c]);
        end
        step(); if (c == 0) clear_ev();
      end
    end
  endtask

  task automatic test_int_gating();
    logic [31:0] pc;
    pc = $urandom & 32'hFFFF_FFFC; mtvec = $urandom & 32'hFFFF_FFFC;
    mstatus = 32'h0; int_flag_i = 8'h01; ex_valid_i = 1; ex_pc_i = pc;
    for (int i = 0; i < int'(SYNC_D) + 4; i++) begin
      #1; n_tests++;
      if (hold_flag_o !== 1'b0) begin
        n_fail++; $display("FAIL int_mie0_hold cyc%0d got %b exp 0", i, hold_flag_o);
      end
      step();
    end
    mstatus = 32'h8; redirect_i = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin redirect_i = 0; jtag_halt_flag_i = 1; end
      #1; n_tests++;
      if (hold_flag_o !== 1'b0) begin
        n_fail++; $display("FAIL int_deferred_hold cyc%0d got %b exp 0", i, hold_flag_o);
      end
      step();
    end
    jtag_halt_flag_i = 0;
    build_trap(32'h8000_000B, pc, mstatus, mtvec);
    foreach (exp_q[c]) begin
      #1; act = cur(); n_tests++;
      if (act !== exp_q[c]) begin
        n_fail++; $display("FAIL ext_int cyc%0d got %h exp %h", c, act, exp_q[c]);
      end
      step(); if (c == 0) clear_ev();
    end
    n_tests++;
    if (mcause !== 32'h8000_000B || mepc !== pc) begin
      n_fail++; $display("FAIL ext_int_csrs got mcause=%h mepc=%h exp %h %h", mcause, mepc, 32'h8000_000B, pc);
    end
    ex_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1; n_tests++;
      if (hold_flag_o !== 1'b0) begin
        n_fail++; $display("FAIL int_no_retrigger cyc%0d got %b exp 0", i, hold_flag_o);
      end
      step();
    end
    clear_ev(); int_flag_i = '0;
    repeat (SYNC_D + 1) step();
  endtask

  task automatic test_simultaneous();
    logic [31:0] pc;
    mstatus = 32'h8; mtvec = $urandom & 32'hFFFF_FFFC;
    int_flag_i = 8'($urandom_range(1, 255));
    repeat (SYNC_D + 1) step();
    pc = $urandom & 32'hFFFF_FFFC;
    ex_valid_i = 1; inst_ecall_i = 1; ex_pc_i = pc;
    build_trap(32'd11, pc, mstatus, mtvec);
    foreach (exp_q[c]) begin
      #1; act = cur(); n_tests++;
      if (act !== exp_q[c]) begin
        n_fail++; $display("FAIL simul_ecall cyc%0d got %h exp %h", c, act, exp_q[c]);
      end
      step(); if (c == 0) clear_ev();
    end
    ex_valid_i = 1; inst_mret_i = 1; ex_pc_i = $urandom;
    build_mret(mstatus, mepc);
    foreach (exp_q[c]) begin
      #1; act = cur(); n_tests++;
      if (act !== exp_q[c]) begin
        n_fail++; $display("FAIL simul_mret cyc%0d got %h exp %h", c, act, exp_q[c]);
      end
      step(); if (c == 0) clear_ev();
    end
    pc = $urandom & 32'hFFFF_FFFC;
    ex_valid_i = 1; ex_pc_i = pc;
    build_trap(32'h8000_000B, pc, mstatus, mtvec);
    foreach (exp_q[c]) begin
      #1; act = cur(); n_tests++;
      if (act !== exp_q[c]) begin
        n_fail++; $display("FAIL simul_int_after_mret cyc%0d got %h exp %h", c, act, exp_q[c]);
      end
      step(); if (c == 0) clear_ev();
    end
    int_flag_i = '0;
    repeat (SYNC_D + 1) step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] pc;
    pc = $urandom & 32'hFFFF_FFFC; mstatus = 32'h8;
    ex_valid_i = 1; inst_ecall_i = 1; ex_pc_i = pc;
    step(); clear_ev(); step();
    #1; n_tests++;
    if (cur() !== {1'b1, 12'h341, pc, 1'b1, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL pre_reset_mepc got %h exp %h", cur(), {1'b1, 12'h341, pc, 1'b1, 1'b0, 32'h0});
    end
    rst_n = 0;
    #1; n_tests++;
    if (cur() !== obs_t'(0)) begin
      n_fail++; $display("FAIL mid_reset_outputs got %h exp 0", cur());
    end
    step(); rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      #1; n_tests++;
      if (int_assert_o !== 1'b0 || hold_flag_o !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_quiet cyc%0d got assert=%b hold=%b exp 0 0", i, int_assert_o, hold_flag_o);
      end
      step();
    end
  endtask

  task automatic test_int_latency();
    logic [31:0] pc;
    pc = $urandom & 32'hFFFF_FFFC; mstatus = 32'h8; mtvec = $urandom & 32'hFFFF_FFFC;
    ex_valid_i = 1; ex_pc_i = pc; int_flag_i = 8'h10;
    for (int i = 0; i < int'(SYNC_D); i++) begin
      #1; n_tests++;
      if (hold_flag_o !== 1'b0) begin
        n_fail++; $display("FAIL int_sync_delay cyc%0d got hold=%b exp 0", i, hold_flag_o);
      end
      step();
    end
    build_trap(32'h8000_000B, pc, mstatus, mtvec);
    foreach (exp_q[c]) begin
      #1; act = cur(); n_tests++;
      if (act !== exp_q[c]) begin
        n_fail++; $display("FAIL int_latency cyc%0d got %h exp %h", c, act, exp_q[c]);
      end
      step(); if (c == 0) clear_ev();
    end
    int_flag_i = '0;
    repeat (SYNC_D + 1) step();
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_mret();
    test_int_gating();
    test_simultaneous();
    test_int_latency();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
